// File: rtl/control_pkg.sv
// Shared definitions for the control unit: state encodings, opcodes,
// ALU function codes and the DECODE dispatch helper.
package control_pkg;

    // Encodings are visible on OutState, so they are fixed explicitly.
    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_e;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

    // First execute state for an opcode; undefined opcodes behave as NOOP.
    function automatic state_e exec_state(input logic [3:0] op);
        state_e st;
        case (op)
            OP_NOOP:  st = ST_NOOP;
            OP_STORE: st = ST_STORE;
            OP_LOAD:  st = ST_LOAD_A;
            OP_ADD:   st = ST_ADD;
            OP_SUB:   st = ST_SUB;
            OP_HALT:  st = ST_HALT;
            default:  st = ST_NOOP;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/control_out_dec.sv
// Moore output decoder for the control unit.
// Inputs : state  - current control state
//          fields - Instr[11:0] (operand fields; opcode is not needed here)
// Outputs: every datapath control strobe/address; strobes depend only on
//          state, address fields are taken combinationally from the fields.
module control_out_dec
    import control_pkg::*;
#(
    parameter int D_AW   = 8,
    parameter int RF_AW  = 4,
    parameter int ALU_SW = 3
) (
    input  state_e              state,
    input  logic [11:0]         fields,
    output logic                pc_clr,
    output logic                pc_up,
    output logic                ir_ld,
    output logic [D_AW-1:0]     d_addr,
    output logic                d_wr,
    output logic                rf_s,
    output logic [RF_AW-1:0]    rf_w_addr,
    output logic                rf_w_en,
    output logic [RF_AW-1:0]    rf_ra_addr,
    output logic [RF_AW-1:0]    rf_rb_addr,
    output logic [ALU_SW-1:0]   alu_s0,
    output logic                halted
);

    // Decode state into outputs; everything defaults to 0 so write strobes
    // can only appear in their own states.
    always_comb begin
        pc_clr     = 1'b0;
        pc_up      = 1'b0;
        ir_ld      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_s0     = ALU_SW'(ALU_PASS);
        halted     = 1'b0;
        case (state)
            ST_INIT: begin
                pc_clr = 1'b1;
            end
            ST_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            ST_LOAD_A, ST_LOAD_B: begin
                d_addr    = D_AW'(fields[11:4]);
                rf_s      = 1'b1;
                rf_w_addr = RF_AW'(fields[3:0]);
                // LOAD_A is the memory latency slot; write only in LOAD_B.
                rf_w_en   = (state == ST_LOAD_B);
            end
            ST_STORE: begin
                d_addr     = D_AW'(fields[7:0]);
                rf_ra_addr = RF_AW'(fields[11:8]);
                d_wr       = 1'b1;
                alu_s0     = ALU_SW'(ALU_PASS);
            end
            ST_ADD, ST_SUB: begin
                rf_ra_addr = RF_AW'(fields[11:8]);
                rf_rb_addr = RF_AW'(fields[7:4]);
                rf_w_addr  = RF_AW'(fields[3:0]);
                rf_w_en    = 1'b1;
                rf_s       = 1'b0;
                alu_s0     = (state == ST_ADD) ? ALU_SW'(ALU_ADD) : ALU_SW'(ALU_SUB);
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                pc_clr = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Control unit: fetch/decode/execute sequencer for NOOP, STORE, LOAD,
// ADD, SUB and HALT.
// Inputs : Clock, Reset_n (async active-low), Instr (from IR Data_out)
// Outputs: PC_clr/PC_up, IR_ld, D_addr/D_wr, RF_s, RF_W_addr/RF_W_en,
//          RF_Ra_addr/RF_Rb_addr, ALU_s0, OutState (debug), Halted.
module control_fsm
    import control_pkg::*;
#(
    parameter int D_AW   = 8,
    parameter int RF_AW  = 4,
    parameter int ALU_SW = 3
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [15:0]         Instr,
    output logic                PC_clr,
    output logic                PC_up,
    output logic                IR_ld,
    output logic [D_AW-1:0]     D_addr,
    output logic                D_wr,
    output logic                RF_s,
    output logic [RF_AW-1:0]    RF_W_addr,
    output logic                RF_W_en,
    output logic [RF_AW-1:0]    RF_Ra_addr,
    output logic [RF_AW-1:0]    RF_Rb_addr,
    output logic [ALU_SW-1:0]   ALU_s0,
    output logic [3:0]          OutState,
    output logic                Halted
);

    state_e state_q;
    state_e state_d;

    // State register; reset drops straight to INIT without waiting for a clock.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Instr is consulted only in DECODE so it cannot
    // disturb the sequence anywhere else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: state_d = exec_state(Instr[15:12]);
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_NOOP, ST_LOAD_B, ST_STORE, ST_ADD, ST_SUB: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    assign OutState = state_q;

    control_out_dec #(
        .D_AW   (D_AW),
        .RF_AW  (RF_AW),
        .ALU_SW (ALU_SW)
    ) u_out_dec (
        .state      (state_q),
        .fields     (Instr[11:0]),
        .pc_clr     (PC_clr),
        .pc_up      (PC_up),
        .ir_ld      (IR_ld),
        .d_addr     (D_addr),
        .d_wr       (D_wr),
        .rf_s       (RF_s),
        .rf_w_addr  (RF_W_addr),
        .rf_w_en    (RF_W_en),
        .rf_ra_addr (RF_Ra_addr),
        .rf_rb_addr (RF_Rb_addr),
        .alu_s0     (ALU_s0),
        .halted     (Halted)
    );

endmodule

// File: tb/tb_control_fsm.sv
// Testbench for control_fsm: directed instructions from the test plan,
// then a random instruction stream with random asynchronous resets,
// checked cycle by cycle against an instruction-timeline reference model.
module tb_control_fsm;

    logic        Clock;
    logic        Reset_n;
    logic [15:0] Instr;
    logic        PC_clr, PC_up, IR_ld, D_wr, RF_s, RF_W_en, Halted;
    logic [7:0]  D_addr;
    logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
    logic [2:0]  ALU_s0;

    int n_total;
    int n_bad;

    control_fsm dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Instr      (Instr),
        .PC_clr     (PC_clr),
        .PC_up      (PC_up),
        .IR_ld      (IR_ld),
        .D_addr     (D_addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .ALU_s0     (ALU_s0),
        .OutState   (OutState),
        .Halted     (Halted)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [29:0] dut_vec;
    assign dut_vec = {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
                      RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, Halted};

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [29:0] pk(
        input logic pc_clr, input logic pc_up, input logic ir_ld,
        input logic [7:0] da, input logic dw, input logic rs,
        input logic [3:0] wa, input logic we, input logic [3:0] ra,
        input logic [3:0] rb, input logic [2:0] alu, input logic h);
        return {pc_clr, pc_up, ir_ld, da, dw, rs, wa, we, ra, rb, alu, h};
    endfunction

    logic [29:0] reset_vec;
    assign reset_vec = {1'b1, 29'd0};

    // Reference model: what the block must show on cycle k of executing
    // instruction ins (k=0 fetch, k=1 decode, k>=2 execute).
    task automatic model(input logic [15:0] ins, input int k,
                         output logic [3:0] st, output logic [29:0] v);
        logic [3:0] op;
        op = ins[15:12];
        v  = 30'd0;
        st = 4'd0;
        if (k == 0) begin
            st = 4'd1;
            v  = pk(1'b0, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
        end else if (k == 1) begin
            st = 4'd2;
        end else begin
            case (op)
                4'd1: begin
                    st = 4'd6;
                    v  = pk(1'b0, 1'b0, 1'b0, ins[7:0], 1'b1, 1'b0, 4'd0, 1'b0,
                            ins[11:8], 4'd0, 3'd0, 1'b0);
                end
                4'd2: begin
                    st = (k == 2) ? 4'd4 : 4'd5;
                    v  = pk(1'b0, 1'b0, 1'b0, ins[11:4], 1'b0, 1'b1, ins[3:0], (k == 3),
                            4'd0, 4'd0, 3'd0, 1'b0);
                end
                4'd3, 4'd4: begin
                    st = (op == 4'd3) ? 4'd7 : 4'd8;
                    v  = pk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, ins[3:0], 1'b1,
                            ins[11:8], ins[7:4], (op == 4'd3) ? 3'd1 : 3'd2, 1'b0);
                end
                4'd5: begin
                    st = 4'd9;
                    v  = pk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
                end
                default: st = 4'd3;
            endcase
        end
    endtask

    // Reset already asserted: hold two more checked half-cycles, release
    // just after an edge so INIT lasts a whole cycle, then check INIT.
    task automatic reset_hold();
        repeat (2) begin
            @(negedge Clock);
            Instr = 16'($urandom);
            check("rst_state", 32'(OutState), 32'd0);
            check("rst_outs", 32'(dut_vec), 32'(reset_vec));
        end
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        Instr   = 16'($urandom);
        @(negedge Clock);
        check("init_state", 32'(OutState), 32'd0);
        check("init_outs", 32'(dut_vec), 32'(reset_vec));
    endtask

    // Mid-cycle asynchronous reset; outputs must change with no edge.
    task automatic async_reset();
        #2 Reset_n = 1'b0;
        #1;
        check("async_state", 32'(OutState), 32'd0);
        check("async_outs", 32'(dut_vec), 32'(reset_vec));
        reset_hold();
    endtask

    // Run one instruction; abort_k >= 0 injects a reset on that cycle.
    // HALT is held for a number of cycles and then left through reset.
    task automatic run_instr(input logic [15:0] ins, input int abort_k);
        int len;
        logic [3:0]  st;
        logic [29:0] v;
        bit is_halt;
        is_halt = (ins[15:12] == 4'd5);
        len = (ins[15:12] == 4'd2) ? 4 : (is_halt ? 14 : 3);
        for (int k = 0; k < len; k++) begin
            @(posedge Clock); #1;
            // Operands only need to be stable while decode/execute use them.
            if (k == 0 || (is_halt && k >= 2)) Instr = 16'($urandom);
            else Instr = ins;
            if (k == abort_k) begin
                async_reset();
                return;
            end
            model(ins, k, st, v);
            @(negedge Clock);
            check("state", 32'(OutState), 32'(st));
            check("outs", 32'(dut_vec), 32'(v));
        end
        if (is_halt) begin
            @(posedge Clock); #1;
            async_reset();
        end
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        Reset_n = 1'b0;
        Instr   = 16'h0000;
        #1;
        check("por_state", 32'(OutState), 32'd0);
        reset_hold();

        run_instr(16'h3123, -1);
        run_instr(16'h2A57, -1);
        run_instr(16'h164C, -1);
        run_instr(16'h4321, -1);
        run_instr(16'hF000, -1);
        run_instr(16'h2A57, 2);
        run_instr(16'h5000, -1);
        run_instr(16'h3123, -1);

        for (int i = 0; i < 200; i++) begin
            logic [15:0] ins;
            int len;
            int ak;
            ins = 16'($urandom);
            if (ins[15:12] == 4'd5 && $urandom_range(0, 3) != 0) ins[15:12] = 4'd3;
            len = (ins[15:12] == 4'd2) ? 4 : 3;
            ak  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_instr(ins, ak);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Control-unit state machine that consumes the 16-bit instruction held in the instruction register and sequences the datapath.
- Drives the PC, the IR load enable, data-memory address/write, register-file addresses/enables and the ALU select.
- Sits directly downstream of the IR: the IR's Load input is this block's IR_ld, and the IR's Data_out feeds this block's Instr.
- Implements fetch/decode/execute for NOOP, STORE, LOAD, ADD, SUB and HALT.

Parameters:
- D_AW, 8, data-memory address width.
- RF_AW, 4, register-file address width.
- ALU_SW, 3, ALU select width.

Ports:
- Clock  input  1  system clock, all state changes on posedge.
- Reset_n  input  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- Instr  input  16  current instruction from IR Data_out.
- PC_clr  output  1  clear program counter.
- PC_up  output  1  increment program counter.
- IR_ld  output  1  load enable to IR.
- D_addr  output  D_AW  data-memory address.
- D_wr  output  1  data-memory write enable.
- RF_s  output  1  RF write-data mux: 1 = memory read data, 0 = ALU result.
- RF_W_addr  output  RF_AW  RF write address.
- RF_W_en  output  1  RF write enable.
- RF_Ra_addr  output  RF_AW  RF read port A address.
- RF_Rb_addr  output  RF_AW  RF read port B address.
- ALU_s0  output  ALU_SW  ALU function: 000 pass A, 001 add, 010 sub.
- OutState  output  4  current state encoding, for debug/display.
- Halted  output  1  high while in HALT.

Behaviour:
Instruction fields:
- op = Instr[15:12].
- NOOP 0000.
- STORE 0001: Ra = [11:8], addr = [7:0].
- LOAD 0010: addr = [11:4], Rd = [3:0].
- ADD 0011 / SUB 0100: Ra = [11:8], Rb = [7:4], Rd = [3:0].
- HALT 0101.
- Opcodes 0110..1111 are undefined and treated as NOOP.

States and encodings:
- INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9.

Transitions (on posedge Clock):
- INIT -> FETCH.
- FETCH -> DECODE.
- DECODE -> state selected by op; undefined op -> NOOP.
- NOOP, LOAD_B, STORE, ADD, SUB -> FETCH.
- LOAD_A -> LOAD_B.
- HALT -> HALT, indefinitely; only reset exits.

Outputs:
- Moore with respect to state; address fields are decoded combinationally from Instr.
- Every output not listed for a state is 0.
- INIT: PC_clr=1.
- FETCH: IR_ld=1, PC_up=1. Instr is valid from DECODE onward (IR captures on the edge that ends FETCH).
- DECODE and NOOP: all 0.
- LOAD_A: D_addr=Instr[11:4], RF_s=1, RF_W_addr=Instr[3:0]. Memory read latency slot.
- LOAD_B: same as LOAD_A, plus RF_W_en=1.
- STORE: D_addr=Instr[7:0], RF_Ra_addr=Instr[11:8], D_wr=1, ALU_s0=000.
- ADD: RF_Ra_addr=Instr[11:8], RF_Rb_addr=Instr[7:4], RF_W_addr=Instr[3:0], RF_W_en=1, RF_s=0, ALU_s0=001.
- SUB: same as ADD, but ALU_s0=010.
- HALT: Halted=1.

Instruction latency:
- NOOP/STORE/ADD/SUB: 3 cycles (FETCH, DECODE, EXEC).
- LOAD: 4 cycles.

Reset:
- Reset_n low forces state=INIT immediately (asynchronously), from any state including mid-LOAD and HALT.
- While reset is held, outputs equal INIT outputs: PC_clr=1, all others 0, OutState=0.
- First state after release is INIT for one full cycle, then FETCH.

Glitch-free strobes:
- D_wr and RF_W_en are asserted only in their named states.
- An Instr change outside DECODE never alters the state path.

Decomposition:
- Package control_pkg holds:
  - state enum (4-bit, encodings above);
  - opcode constants OP_NOOP..OP_HALT;
  - ALU codes ALU_PASS/ALU_ADD/ALU_SUB.
- Optional combinational sub-module control_out_dec (state + Instr -> outputs), keeping the state register and next-state logic in control_fsm.

Test Plan:
1. Reset_n=0 for 2 cycles, then 1 -> during reset OutState=0, PC_clr=1; after release INIT one cycle, then FETCH with IR_ld=1, PC_up=1.
2. Instr=16'h3123 (ADD R3=R1+R2) -> DECODE then ADD state with Ra=1, Rb=2, W_addr=3, W_en=1, ALU_s0=001, RF_s=0; back to FETCH next cycle.
3. Instr=16'h2A57 (LOAD R7<-D[0xA5]) -> LOAD_A: D_addr=0xA5, RF_s=1, W_en=0; LOAD_B: W_en=1, W_addr=7; then FETCH.
4. Instr=16'h164C (STORE D[0x4C]<-R6) -> STORE: D_addr=0x4C, Ra=6, D_wr=1 for exactly one cycle. Instr=16'h4321 (SUB) -> ALU_s0=010.
5. Instr=16'h5000 (HALT) -> HALT, Halted=1, held for 10+ cycles with no IR_ld/PC_up. Instr=16'hF000 -> NOOP then FETCH.
6. Assert Reset_n=0 asynchronously mid-cycle while in LOAD_A -> OutState=0 immediately without waiting for an edge; no RF_W_en pulse occurs.
